// File: rtl/cla32_adder.sv
// 32-bit two-level carry-lookahead adder with a single registered output stage.
// Four-bit lookahead units form 16-bit blocks; a top level joins the two blocks.

// Four-input lookahead carry unit. The same equations are used for a 4-bit
// group (bit g/p in) and for combining four group generate/propagate pairs.
module cla_lcu4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       c_in,
    output logic [3:0] c,
    output logic       g_out,
    output logic       p_out
);

    always_comb begin
        c[0]  = c_in;
        c[1]  = g[0] | (p[0] & c_in);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
        g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_out = &p;
    end

endmodule

// 16-bit lookahead block: four 4-bit groups plus a second-level unit that
// supplies every group carry-in, so no carry ripples between groups.
module cla16_unit (
    input  logic [15:0] g,
    input  logic [15:0] p,
    input  logic        c_in,
    output logic [15:0] c,
    output logic        g16,
    output logic        p16
);

    logic [3:0] grp_g;
    logic [3:0] grp_p;
    logic [3:0] grp_c;

    // Group G/P never depend on a carry, so feeding the level-2 carries back
    // into the groups forms no combinational loop.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        cla_lcu4 u_grp (
            .g     (g[4*k +: 4]),
            .p     (p[4*k +: 4]),
            .c_in  (grp_c[k]),
            .c     (c[4*k +: 4]),
            .g_out (grp_g[k]),
            .p_out (grp_p[k])
        );
    end

    cla_lcu4 u_lvl2 (
        .g     (grp_g),
        .p     (grp_p),
        .c_in  (c_in),
        .c     (grp_c),
        .g_out (g16),
        .p_out (p16)
    );

endmodule

module cla32_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic        G,
    output logic        P,
    output logic        c32,
    output logic [31:0] sum
);

    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [31:0] carry;
    logic        g16_lo, p16_lo;
    logic        g16_hi, p16_hi;
    logic        c16;
    logic        g_all, p_all, c_out;
    logic [31:0] sum_next;

    // XOR propagate lets the sum bit reuse p directly.
    assign bit_g = x & y;
    assign bit_p = x ^ y;

    cla16_unit u_lo (
        .g    (bit_g[15:0]),
        .p    (bit_p[15:0]),
        .c_in (c_in),
        .c    (carry[15:0]),
        .g16  (g16_lo),
        .p16  (p16_lo)
    );

    cla16_unit u_hi (
        .g    (bit_g[31:16]),
        .p    (bit_p[31:16]),
        .c_in (c16),
        .c    (carry[31:16]),
        .g16  (g16_hi),
        .p16  (p16_hi)
    );

    assign c16      = g16_lo | (p16_lo & c_in);
    assign g_all    = g16_hi | (p16_hi & g16_lo);
    assign p_all    = p16_hi & p16_lo;
    assign c_out    = g_all | (p_all & c_in);
    assign sum_next = bit_p ^ carry;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            c32 <= 1'b0;
            G   <= 1'b0;
            P   <= 1'b0;
        end else begin
            sum <= sum_next;
            c32 <= c_out;
            G   <= g_all;
            P   <= p_all;
        end
    end

endmodule

// File: tb/tb_cla32_adder.sv
// Self-checking bench for cla32_adder: stimulus pushes expected results into a
// scoreboard queue; a monitor pops and compares one result per cycle.
module tb_cla32_adder;

    typedef struct {
        logic [31:0] sum;
        logic        c32;
        logic        g;
        logic        p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        c_in = 1'b0;
    logic        G, P, c32;
    logic [31:0] sum;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    cla32_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .G     (G),
        .P     (P),
        .c32   (c32),
        .sum   (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 33-bit arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        exp_t        e;
        logic [32:0] full;
        logic [32:0] no_cin;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        no_cin = {1'b0, a} + {1'b0, b};
        e.sum  = full[31:0];
        e.c32  = full[32];
        e.g    = no_cin[32];
        e.p    = ((a ^ b) == 32'hFFFF_FFFF);
        return e;
    endfunction

    // Drive one operand set just after a falling edge; it is captured on the
    // next rising edge and checked by the monitor at the falling edge after.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        @(negedge clk);
        #1;
        x    = a;
        y    = b;
        c_in = ci;
        sb.push_back(model(a, b, ci));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_sum"}, 64'(sum), 64'd0);
        check({tag, "_c32"}, 64'(c32), 64'd0);
        check({tag, "_G"},   64'(G),   64'd0);
        check({tag, "_P"},   64'(P),   64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 64'(sum), 64'(e.sum));
            check("c32", 64'(c32), 64'(e.c32));
            check("G",   64'(G),   64'(e.g));
            check("P",   64'(P),   64'(e.p));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held low while clocking with live operands.
        x    = 32'd1;
        y    = 32'd2;
        c_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("rst_hold");

        // Release reset and run the directed cases.
        #1;
        rst_n = 1'b1;
        drive(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        drive(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drive(32'h0000_0000, 32'h0000_0000, 1'b0);
        // Back-to-back operand sets for pipelining.
        drive(32'h1234_5678, 32'h8765_4321, 1'b0);
        drive(32'h00FF_00FF, 32'h0F0F_0F0F, 1'b1);
        drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);

        // Mid-stream async reset: in-flight result discarded, outputs clear at once.
        drive(32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        @(posedge clk);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("rst_async");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cleared("rst_low");
        #1;
        rst_n = 1'b1;

        // Random regression.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            drive(a, ~a, 1'($urandom_range(0, 1)));
        end

        // Drain; every pushed result must have been consumed.
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla32_adder.md
Name: cla32_adder

Overview:
- 32-bit two-level carry-lookahead adder with registered outputs.
- Computes x + y + c_in and produces the 32-bit sum, the carry-out, and the group generate/propagate signals over all 32 bits.
- Intended as a datapath adder, or as a leaf of a wider lookahead tree through G/P.
- Combinational lookahead core followed by one output register stage.

Parameters:
- none (width fixed at 32)

Ports:
- clk    input   1   rising-edge clock; all outputs registered on it
- rst_n  input   1   asynchronous reset, active-low
- x      input   32  addend A
- y      input   32  addend B
- c_in   input   1   carry-in to bit 0
- G      output  1   32-bit group generate (registered)
- P      output  1   32-bit group propagate (registered)
- c32    output  1   carry-out of bit 31 (registered)
- sum    output  32  (x + y + c_in) mod 2^32 (registered)

Behaviour:
- Reset:
  - rst_n low asynchronously forces sum=0, c32=0, G=0, P=0, regardless of clk.
  - Outputs hold those values while rst_n is low.
  - Deassertion takes effect at the next rising clk edge.
- Bit level, i = 0..31:
  - g_i = x_i & y_i
  - p_i = x_i ^ y_i (XOR propagate; required so the sum bit reuses it)
- Level 1: eight 4-bit CLA groups (bits 4k..4k+3).
  - Internal carries are computed in lookahead form from the group carry-in.
  - Each group outputs:
    - Gg = g3 | p3g2 | p3p2g1 | p3p2p1g0
    - Pg = p3p2p1p0
- Level 2: two 16-bit lookahead units, each combining four groups the same way.
  - Each produces carries into its groups plus its own G16/P16.
- Top:
  - G = G16hi | (P16hi & G16lo)
  - P = P16hi & P16lo
  - Carry into bit 16 = G16lo | (P16lo & c_in)
  - c32 = G | (P & c_in)
- No ripple chain between groups; every group carry-in comes from lookahead logic.
- Sum: sum_i = p_i ^ c_i, with c_0 = c_in.
- Timing:
  - Inputs are sampled on each rising clk edge with rst_n high.
  - Results appear on the outputs one cycle later (latency 1, throughput 1/cycle).
  - Inputs need only be stable for setup/hold around the edge.
- G and P depend only on x and y, never on c_in.
- Boundary cases:
  - All propagate (y = ~x): P=1, G=0, sum = all ones when c_in=0; sum=0 with c32=1 when c_in=1.
  - x=y=FFFFFFFF, c_in=1: sum=FFFFFFFF, c32=1, G=1, P=0.
  - Wrap-around is modular; overflow is reported only through c32. No signed overflow flag.
- X/undriven inputs: no requirement beyond propagating X. The bench must drive c_in before checking.
- Reset asserted mid-stream: the in-flight result is discarded; the first valid output follows the first edge after deassertion.

Test Plan:
- Reset: hold rst_n=0 with x=1, y=2 and toggle clk → sum=0, c32=0, G=0, P=0. Assert rst_n low between edges → outputs clear immediately.
- Full propagate: x=00000001, y=FFFFFFFE, c_in=0 → next cycle sum=FFFFFFFF, c32=0, G=0, P=1. Same inputs with c_in=1 → sum=00000000, c32=1, G=0, P=1.
- Max generate: x=FFFFFFFF, y=FFFFFFFF, c_in=1 → sum=FFFFFFFF, c32=1, G=1, P=0.
- Group boundary carries: x=0000FFFF, y=00000001, c_in=0 → sum=00010000, c32=0. x=7FFFFFFF, y=00000001 → sum=80000000, c32=0, G=0, P=0.
- Pipelining: present three different operand sets on consecutive edges → outputs match each set's result exactly one cycle later, in order, with no bubbles.
- Random regression: ≥10k random x, y, c_in → {c32,sum} == x+y+c_in (33-bit). G == (carry-out with c_in=0). P == (x^y == FFFFFFFF).
